// File: rtl/rr_grant_pkg.sv
// Shared types and constants for the round-robin grant controller.
package rr_grant_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OFFER = 2'd1,
      BUSY  = 2'd2
   } state_e;

   localparam int unsigned STAT_W = 16;

   // Index width helper that never returns 0, so a single-entry vector still gets a 1-bit index.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_grant_ctrl_ff1.sv
// LSB-first find-first-one: one-hot of the lowest set bit, its binary index, and an any flag.
module rr_ff1_lsb #(
   parameter int unsigned DW = 4,
   parameter int unsigned IW = 2
) (
   input  logic [DW-1:0] in_i,
   output logic [DW-1:0] onehot_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   logic found;

   // Scan upward; the first set bit seen is the winner.
   always_comb begin
      onehot_o = '0;
      idx_o    = '0;
      found    = 1'b0;
      for (int unsigned i = 0; i < DW; i++) begin
         if (in_i[i] && !found) begin
            found       = 1'b1;
            onehot_o[i] = 1'b1;
            idx_o       = IW'(i);
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: IDLE -> OFFER (valid/ready) -> BUSY (until done) -> IDLE.
// Optional per-requester saturating grant counters when RR_GRANT_CTRL_STATS_EN is defined.
module rr_grant_ctrl
   import rr_grant_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = clog2_min1(N)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [N-1:0]     req_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             gnt_valid_o,
   input  logic             gnt_ready_i,
   input  logic             done_i,
   output logic             busy_o
`ifdef RR_GRANT_CTRL_STATS_EN
   ,
   output logic [N*STAT_W-1:0] stat_cnt_o
`endif
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;

   logic [N-1:0]     mask;
   logic [N-1:0]     m_onehot, u_onehot;
   logic [IDX_W-1:0] m_idx, u_idx;
   logic             m_any, u_any;

   // Priority mask: requesters at or above the pointer are eligible first.
   always_comb begin
      mask = '0;
      for (int unsigned i = 0; i < N; i++) begin
         mask[i] = (IDX_W'(i) >= ptr_q);
      end
   end

   rr_ff1_lsb #(.DW(N), .IW(IDX_W)) u_ff1_masked (
      .in_i     (req_i & mask),
      .onehot_o (m_onehot),
      .idx_o    (m_idx),
      .any_o    (m_any)
   );

   rr_ff1_lsb #(.DW(N), .IW(IDX_W)) u_ff1_unmasked (
      .in_i     (req_i),
      .onehot_o (u_onehot),
      .idx_o    (u_idx),
      .any_o    (u_any)
   );

   // Next-state, grant and pointer update.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      gnt_idx_d = gnt_idx_q;
      case (state_q)
         IDLE: begin
            if (u_any) begin
               gnt_d     = m_any ? m_onehot : u_onehot;
               gnt_idx_d = m_any ? m_idx    : u_idx;
               state_d   = OFFER;
            end
         end
         OFFER: begin
            // Ready takes precedence over a same-cycle withdraw.
            if (gnt_ready_i) begin
               state_d = BUSY;
            end else if (!req_i[gnt_idx_q]) begin
               state_d   = IDLE;
               gnt_d     = '0;
               gnt_idx_d = '0;
            end
         end
         BUSY: begin
            if (done_i) begin
               state_d   = IDLE;
               gnt_d     = '0;
               gnt_idx_d = '0;
               ptr_d     = (gnt_idx_q == IDX_W'(N - 1)) ? '0 : gnt_idx_q + 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            gnt_d     = '0;
            gnt_idx_d = '0;
         end
      endcase
   end

   // State, pointer and grant registers.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         gnt_q     <= '0;
         gnt_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         gnt_idx_q <= gnt_idx_d;
      end
   end

   assign gnt_o       = gnt_q;
   assign gnt_idx_o   = gnt_idx_q;
   assign gnt_valid_o = (state_q == OFFER);
   assign busy_o      = (state_q == BUSY);

`ifdef RR_GRANT_CTRL_STATS_EN
   logic [STAT_W-1:0] cnt_q [N];
   logic [STAT_W-1:0] cnt_d [N];

   // Count accepted grants per requester, saturating at all-ones.
   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         cnt_d[i] = cnt_q[i];
      end
      if (state_q == OFFER && gnt_ready_i && cnt_q[gnt_idx_q] != '1) begin
         cnt_d[gnt_idx_q] = cnt_q[gnt_idx_q] + 1'b1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         for (int unsigned i = 0; i < N; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Flatten counters, requester i in bits [i*STAT_W +: STAT_W].
   always_comb begin
      stat_cnt_o = '0;
      for (int unsigned i = 0; i < N; i++) begin
         stat_cnt_o[i*STAT_W +: STAT_W] = cnt_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl (N=4). Define RR_GRANT_CTRL_STATS_EN to include the counter test.
module tb_rr_grant_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic [3:0] req_i;
   logic [3:0] gnt_o;
   logic [1:0] gnt_idx_o;
   logic       gnt_valid_o;
   logic       gnt_ready_i;
   logic       done_i;
   logic       busy_o;
`ifdef RR_GRANT_CTRL_STATS_EN
   logic [63:0] stat_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   rr_grant_ctrl #(.N(4)) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .req_i       (req_i),
      .gnt_o       (gnt_o),
      .gnt_idx_o   (gnt_idx_o),
      .gnt_valid_o (gnt_valid_o),
      .gnt_ready_i (gnt_ready_i),
      .done_i      (done_i),
      .busy_o      (busy_o)
`ifdef RR_GRANT_CTRL_STATS_EN
      ,
      .stat_cnt_o  (stat_cnt_o)
`endif
   );

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_n_i     = 1'b0;
      req_i       = '0;
      gnt_ready_i = 1'b0;
      done_i      = 1'b0;
      tick();
      tick();
      rst_n_i = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt_o); end
      checks++; if (gnt_idx_o !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", gnt_idx_o); end
      checks++; if (gnt_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", gnt_valid_o); end
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
   endtask

   // req=1010 from ptr 0 -> requester 1; after done ptr becomes 2.
   task automatic test_basic();
      req_i = 4'b1010;
      tick();
      checks++; if (gnt_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", gnt_valid_o); end
      checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL basic_gnt got %b exp 0010", gnt_o); end
      checks++; if (gnt_idx_o !== 2'd1) begin errors++; $display("FAIL basic_idx got %0d exp 1", gnt_idx_o); end
      gnt_ready_i = 1'b1;
      tick();
      checks++; if (busy_o !== 1'b1 || gnt_valid_o !== 1'b0) begin errors++; $display("FAIL basic_busy got busy=%b valid=%b exp 1/0", busy_o, gnt_valid_o); end
      checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL basic_gnt_hold got %b exp 0010", gnt_o); end
      gnt_ready_i = 1'b0;
      done_i      = 1'b1;
      req_i       = 4'b0000;
      tick();
      done_i = 1'b0;
      checks++; if (busy_o !== 1'b0 || gnt_o !== 4'b0000) begin errors++; $display("FAIL basic_done got busy=%b gnt=%b exp 0/0000", busy_o, gnt_o); end
   endtask

   // ptr=2, req=0011 -> masked empty, wrap to requester 0.
   task automatic test_wrap();
      req_i = 4'b0011;
      tick();
      checks++; if (gnt_o !== 4'b0001 || gnt_idx_o !== 2'd0) begin errors++; $display("FAIL wrap_gnt got %b/%0d exp 0001/0", gnt_o, gnt_idx_o); end
      req_i = 4'b0000;
      gnt_ready_i = 1'b1;
      tick();
      gnt_ready_i = 1'b0;
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
   endtask

   // All requesting: order 0,1,2,3,0 with an idle bubble after each done.
   task automatic test_back_to_back();
      logic [1:0] exp_order [5];
      exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      req_i       = 4'b1111;
      gnt_ready_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (gnt_valid_o !== 1'b1 || gnt_idx_o !== exp_order[k] || gnt_o !== (4'b0001 << exp_order[k])) begin
            errors++;
            $display("FAIL rr_grant%0d got valid=%b idx=%0d gnt=%b exp idx=%0d", k, gnt_valid_o, gnt_idx_o, gnt_o, exp_order[k]);
         end
         tick();
         checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rr_busy%0d got %b exp 1", k, busy_o); end
         tick();
         done_i = 1'b1;
         tick();
         done_i = 1'b0;
         checks++;
         if (busy_o !== 1'b0 || gnt_valid_o !== 1'b0 || gnt_o !== 4'b0000) begin
            errors++;
            $display("FAIL rr_bubble%0d got busy=%b valid=%b gnt=%b exp 0/0/0000", k, busy_o, gnt_valid_o, gnt_o);
         end
      end
      req_i       = 4'b0000;
      gnt_ready_i = 1'b0;
      tick();
   endtask

   // Withdraw keeps ptr; ready beats a same-cycle withdraw.
   task automatic test_withdraw();
      do_reset();
      req_i = 4'b0001;
      tick();
      req_i = 4'b0000;
      gnt_ready_i = 1'b1;
      tick();
      gnt_ready_i = 1'b0;
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      // ptr is now 1
      req_i = 4'b0100;
      tick();
      checks++; if (gnt_idx_o !== 2'd2 || gnt_valid_o !== 1'b1) begin errors++; $display("FAIL wd_offer got idx=%0d valid=%b exp 2/1", gnt_idx_o, gnt_valid_o); end
      req_i = 4'b0000;
      tick();
      checks++;
      if (gnt_valid_o !== 1'b0 || gnt_o !== 4'b0000 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL wd_idle got valid=%b gnt=%b busy=%b exp 0/0000/0", gnt_valid_o, gnt_o, busy_o);
      end
      req_i = 4'b0011;
      tick();
      checks++; if (gnt_idx_o !== 2'd1 || gnt_o !== 4'b0010) begin errors++; $display("FAIL wd_ptr_kept got idx=%0d gnt=%b exp 1/0010", gnt_idx_o, gnt_o); end
      req_i = 4'b0000;
      gnt_ready_i = 1'b1;
      tick();
      gnt_ready_i = 1'b0;
      checks++; if (busy_o !== 1'b1 || gnt_o !== 4'b0010) begin errors++; $display("FAIL wd_ready_wins got busy=%b gnt=%b exp 1/0010", busy_o, gnt_o); end
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
   endtask

   // Reset during BUSY clears everything incl. ptr; done in IDLE is ignored.
   task automatic test_reset_busy();
      // ptr is 2 here
      req_i = 4'b1000;
      tick();
      gnt_ready_i = 1'b1;
      req_i = 4'b0000;
      tick();
      gnt_ready_i = 1'b0;
      checks++; if (busy_o !== 1'b1 || gnt_idx_o !== 2'd3) begin errors++; $display("FAIL rb_setup got busy=%b idx=%0d exp 1/3", busy_o, gnt_idx_o); end
      rst_n_i = 1'b0;
      tick();
      rst_n_i = 1'b1;
      checks++;
      if (busy_o !== 1'b0 || gnt_valid_o !== 1'b0 || gnt_o !== 4'b0000 || gnt_idx_o !== 2'd0) begin
         errors++;
         $display("FAIL rb_abort got busy=%b valid=%b gnt=%b idx=%0d exp all 0", busy_o, gnt_valid_o, gnt_o, gnt_idx_o);
      end
      done_i = 1'b1;
      tick();
      done_i = 1'b0;
      checks++; if (busy_o !== 1'b0 || gnt_valid_o !== 1'b0) begin errors++; $display("FAIL rb_idle_done got busy=%b valid=%b exp 0/0", busy_o, gnt_valid_o); end
      req_i = 4'b1001;
      tick();
      checks++; if (gnt_idx_o !== 2'd0 || gnt_o !== 4'b0001) begin errors++; $display("FAIL rb_ptr_zero got idx=%0d gnt=%b exp 0/0001", gnt_idx_o, gnt_o); end
      req_i = 4'b0000;
      tick();
   endtask

`ifdef RR_GRANT_CTRL_STATS_EN
   // 70000 accepted grants to requester 3 saturate its counter only.
   task automatic test_stats();
      do_reset();
      req_i       = 4'b1000;
      gnt_ready_i = 1'b1;
      done_i      = 1'b1;
      for (int k = 0; k < 70000 * 3; k++) begin
         tick();
      end
      req_i       = 4'b0000;
      gnt_ready_i = 1'b0;
      tick();
      tick();
      done_i = 1'b0;
      checks++; if (stat_cnt_o[63:48] !== 16'hFFFF) begin errors++; $display("FAIL stats_sat got %h exp ffff", stat_cnt_o[63:48]); end
      checks++; if (stat_cnt_o[47:0] !== 48'h0) begin errors++; $display("FAIL stats_others got %h exp 0", stat_cnt_o[47:0]); end
   endtask
`endif

   initial begin
      rst_n_i     = 1'b0;
      req_i       = '0;
      gnt_ready_i = 1'b0;
      done_i      = 1'b0;
      #2;
      test_reset();
      test_basic();
      test_wrap();
      test_back_to_back();
      test_withdraw();
      test_reset_busy();
`ifdef RR_GRANT_CTRL_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
